// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared helpers for the seq_detector slice.
// Optional match counter is compiled in with SEQDET_COUNT_EN.
package seqdet_pkg;

  localparam int SEQ_SYM_MAX = 32;
  localparam int SEQ_PAT_MAX = 16;
  localparam int SEQ_VEC_MAX = SEQ_SYM_MAX * SEQ_PAT_MAX;

  localparam logic [5:0] SEQ_PAT_DEF = {2'd3, 2'd2, 2'd1};

  function automatic int st_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Caller truncates the result to its own symbol width.
  function automatic logic [SEQ_SYM_MAX-1:0] pat_sym(
    input logic [SEQ_VEC_MAX-1:0] pat,
    input int                     idx,
    input int                     sym_w
  );
    logic [SEQ_VEC_MAX-1:0] sh;
    sh = pat >> (idx * sym_w);
    return sh[SEQ_SYM_MAX-1:0];
  endfunction

endpackage

// File: rtl/seqdet_next.sv
// seqdet_next: longest-suffix next-state search for seq_detector.
// One candidate per possible current state, then a final select.
module seqdet_next
  import seqdet_pkg::*;
#(
  parameter  int SYM_W   = 2,
  parameter  int PAT_LEN = 3,
  localparam int ST_W    = st_w(PAT_LEN)
) (
  input  logic [SYM_W*PAT_LEN-1:0] i_pat,
  input  logic [ST_W-1:0]          i_state,
  input  logic [SYM_W-1:0]         i_sym,
  input  logic                     i_overlap,
  output logic [ST_W-1:0]          o_next
);

  logic [SYM_W-1:0]            w_p [PAT_LEN];
  logic [PAT_LEN:0][ST_W-1:0]  w_nk;
  logic [ST_W-1:0]             w_k;

  for (genvar g = 0; g < PAT_LEN; g++) begin : g_sym
    assign w_p[g] = SYM_W'(pat_sym(SEQ_VEC_MAX'(i_pat), g, SYM_W));
  end

  // History for state kc is pattern[0..kc-1] followed by i_sym.
  for (genvar kc = 0; kc <= PAT_LEN; kc++) begin : g_k
    localparam int JMAX = (kc + 1 < PAT_LEN) ? kc + 1 : PAT_LEN;
    logic [ST_W-1:0] w_c;
    logic            w_ok;

    always_comb begin
      w_c  = '0;
      w_ok = 1'b0;
      for (int j = 1; j <= JMAX; j++) begin
        w_ok = (w_p[j-1] == i_sym);
        for (int m = 0; m < j - 1; m++) begin
          if (w_p[m] != w_p[kc+1-j+m]) w_ok = 1'b0;
        end
        if (w_ok) w_c = ST_W'(j);
      end
    end

    assign w_nk[kc] = w_c;
  end

  assign w_k = (!i_overlap && i_state == ST_W'(PAT_LEN)) ? '0 : i_state;
  assign o_next = w_nk[w_k];

endmodule

// File: rtl/seq_detector.sv
// seq_detector: runtime-loadable serial pattern detector.
// Define SEQDET_COUNT_EN to build the saturating hit counter.
module seq_detector
  import seqdet_pkg::*;
#(
  parameter  int                       SYM_W   = 2,
  parameter  int                       PAT_LEN = 3,
  parameter  logic [SYM_W*PAT_LEN-1:0] PAT_RST = SEQ_PAT_DEF,
  parameter  int                       CNT_W   = 8,
  localparam int                       ST_W    = st_w(PAT_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym,
  input  logic                     overlap,
  input  logic                     pat_load,
  input  logic [SYM_W*PAT_LEN-1:0] pat_in,
  input  logic                     cnt_clr,
  output logic                     match,
  output logic                     hit,
  output logic [ST_W-1:0]          state,
  output logic [CNT_W-1:0]         hit_cnt
);

  logic [SYM_W*PAT_LEN-1:0] r_pat;
  logic [ST_W-1:0]          r_state;
  logic                     r_match;
  logic                     r_hit;
  logic [ST_W-1:0]          w_next;
  logic                     w_done;
  logic                     w_hit_d;

  seqdet_next #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN)
  ) u_next (
    .i_pat     (r_pat),
    .i_state   (r_state),
    .i_sym     (sym),
    .i_overlap (overlap),
    .o_next    (w_next)
  );

  assign w_done  = (w_next == ST_W'(PAT_LEN));
  assign w_hit_d = sym_valid && !pat_load && w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat   <= PAT_RST;
      r_state <= '0;
      r_match <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_hit <= w_hit_d;
      if (pat_load) begin
        r_pat   <= pat_in;
        r_state <= '0;
        r_match <= 1'b0;
      end else if (sym_valid) begin
        r_state <= w_next;
        r_match <= w_done;
      end
    end
  end

  assign state = r_state;
  assign match = r_match;
  assign hit   = r_hit;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hit_d && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hit_cnt = r_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign hit_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: vector table plus scoreboard for seq_detector.
// Counter expectations follow SEQDET_COUNT_EN.
module tb_seq_detector;

  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym;
  logic       overlap;
  logic       pat_load;
  logic [5:0] pat_in;
  logic       cnt_clr;
  logic       match;
  logic       hit;
  logic [1:0] state;
  logic [CNT_W-1:0] hit_cnt;

  seq_detector #(
    .SYM_W   (2),
    .PAT_LEN (3),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (sym_valid),
    .sym       (sym),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .match     (match),
    .hit       (hit),
    .state     (state),
    .hit_cnt   (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       ov;
    logic       ld;
    logic [5:0] pat;
    logic       clr;
    logic [1:0] st;
    logic       m;
    logic       h;
  } vec_t;

  typedef struct {
    logic [1:0]       st;
    logic             m;
    logic             h;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  localparam logic [5:0] P111 = {2'd1, 2'd1, 2'd1};
  localparam logic [5:0] P121 = {2'd1, 2'd2, 2'd1};

  vec_t va[$];
  vec_t vb[$];
  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic vec_t acc(int s, int ov, int st, int m, int h,
                               int clr = 0);
    vec_t t;
    t = '{1'b1, 2'(s), 1'(ov), 1'b0, 6'd0, 1'(clr), 2'(st), 1'(m), 1'(h)};
    return t;
  endfunction

  function automatic vec_t idl(int s, int st, int m);
    vec_t t;
    t = '{1'b0, 2'(s), 1'b0, 1'b0, 6'd0, 1'b0, 2'(st), 1'(m), 1'b0};
    return t;
  endfunction

  function automatic vec_t lod(logic [5:0] p, int v, int s, int ov,
                               int clr = 0);
    vec_t t;
    t = '{1'(v), 2'(s), 1'(ov), 1'b1, p, 1'(clr), 2'd0, 1'b0, 1'b0};
    return t;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || match !== e.m || hit !== e.h ||
          hit_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got st=%0d m=%0b h=%0b cnt=%0d want st=%0d m=%0b h=%0b cnt=%0d",
                 name, state, match, hit, hit_cnt, e.st, e.m, e.h, e.cnt);
      end
    end
  endtask

  task automatic check_zero(input string name);
    n_run++;
    if (state !== 2'd0 || match !== 1'b0 || hit !== 1'b0 ||
        hit_cnt !== '0) begin
      n_fail++;
      $display("FAIL %s: got st=%0d m=%0b h=%0b cnt=%0d want all 0",
               name, state, match, hit, hit_cnt);
    end
  endtask

  task automatic step(input vec_t t, input string name);
    sym_valid = t.v;
    sym       = t.s;
    overlap   = t.ov;
    pat_load  = t.ld;
    pat_in    = t.pat;
    cnt_clr   = t.clr;
`ifdef SEQDET_COUNT_EN
    if (t.clr) m_cnt = '0;
    else if (t.h && m_cnt != '1) m_cnt = m_cnt + 1'b1;
`else
    m_cnt = '0;
`endif
    sb.push_back('{t.st, t.m, t.h, m_cnt});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Default pattern 1,2,3, non-overlapping.
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    va.push_back(acc(3, 0, 3, 1, 1));
    va.push_back(idl(0, 3, 1));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    va.push_back(acc(2, 0, 0, 0, 0));
    va.push_back(acc(3, 0, 0, 0, 0));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    va.push_back(acc(3, 0, 3, 1, 1));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    va.push_back(acc(3, 0, 3, 1, 1));
    va.push_back(acc(3, 0, 0, 0, 0));
    // Pattern 1,1,1 overlapping; counter saturates at 3.
    va.push_back(lod(P111, 0, 0, 1, 1));
    va.push_back(acc(1, 1, 1, 0, 0));
    va.push_back(acc(1, 1, 2, 0, 0));
    va.push_back(acc(1, 1, 3, 1, 1));
    va.push_back(acc(1, 1, 3, 1, 1));
    va.push_back(acc(1, 1, 3, 1, 1));
    va.push_back(acc(1, 1, 3, 1, 1));
    va.push_back(acc(0, 1, 0, 0, 0));
    // Same pattern non-overlapping; clear races a hit.
    va.push_back(acc(1, 0, 1, 0, 0, 1));
    va.push_back(acc(1, 0, 2, 0, 0));
    va.push_back(acc(1, 0, 3, 1, 1));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(1, 0, 2, 0, 0));
    va.push_back(acc(1, 0, 3, 1, 1, 1));
    va.push_back(acc(1, 1, 3, 1, 1));
    // Pattern 1,2,1: overlap reuses the trailing 1.
    va.push_back(lod(P121, 0, 0, 1));
    va.push_back(acc(1, 1, 1, 0, 0));
    va.push_back(acc(2, 1, 2, 0, 0));
    va.push_back(acc(1, 1, 3, 1, 1));
    va.push_back(acc(2, 1, 2, 0, 0));
    va.push_back(acc(1, 1, 3, 1, 1));
    va.push_back(acc(2, 0, 0, 0, 0));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    // Load wins over a coincident symbol that would complete 1,2,1.
    va.push_back(lod(P111, 1, 1, 0));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(1, 0, 2, 0, 0));
    // Idle gap in state 2, then complete.
    va.push_back(lod(P121, 0, 0, 0));
    va.push_back(acc(1, 0, 1, 0, 0));
    va.push_back(acc(2, 0, 2, 0, 0));
    for (int i = 0; i < 5; i++) va.push_back(idl(3, 2, 0));
    va.push_back(acc(1, 0, 3, 1, 1));
    // After reset the default pattern 1,2,3 is back.
    vb.push_back(acc(1, 0, 1, 0, 0));
    vb.push_back(acc(2, 0, 2, 0, 0));
    vb.push_back(acc(3, 0, 3, 1, 1));
    vb.push_back(idl(0, 3, 1));

    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym       = '0;
    overlap   = 1'b0;
    pat_load  = 1'b0;
    pat_in    = '0;
    cnt_clr   = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < va.size(); i++)
      step(va[i], $sformatf("va%0d", i));

    #2;
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    pat_load  = 1'b0;
    cnt_clr   = 1'b0;
    #1;
    check_zero("async_rst");
    m_cnt = '0;
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vb.size(); i++)
      step(vb[i], $sformatf("vb%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
